// File: rtl/reg_file_sb.sv
// Register file with three combinational read ports, a short and a long-latency
// write port, and a per-register busy scoreboard for long-latency destinations.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int HARD_ZERO  = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] regfile_raddr_rs1_i,
  input  logic [ADDR_WIDTH-1:0] regfile_raddr_rs2_i,
  input  logic [ADDR_WIDTH-1:0] regfile_raddr_rs3_i,
  output logic [DATA_WIDTH-1:0] regfile_rs1_o,
  output logic [DATA_WIDTH-1:0] regfile_rs2_o,
  output logic [DATA_WIDTH-1:0] regfile_rs3_o,
  output logic                  regfile_rs1_busy_o,
  output logic                  regfile_rs2_busy_o,
  output logic                  regfile_rs3_busy_o,
  input  logic                  regfile_we_i,
  input  logic [ADDR_WIDTH-1:0] regfile_waddr_i,
  input  logic [DATA_WIDTH-1:0] regfile_data_i,
  input  logic                  regfile_lwe_i,
  input  logic [ADDR_WIDTH-1:0] regfile_lwaddr_i,
  input  logic [DATA_WIDTH-1:0] regfile_ldata_i,
  input  logic                  regfile_rsv_i,
  input  logic [ADDR_WIDTH-1:0] regfile_rsv_addr_i,
  output logic                  regfile_busy_any_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_next;

  logic                  we_ok;
  logic                  lwe_ok;
  logic                  rsv_ok;

  logic [ADDR_WIDTH-1:0] raddr [3];
  logic [DATA_WIDTH-1:0] rdata [3];
  logic                  rbusy [3];

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] addr);
    return (HARD_ZERO != 0) && (addr == '0);
  endfunction

  assign we_ok  = regfile_we_i  && !is_zero(regfile_waddr_i);
  assign lwe_ok = regfile_lwe_i && !is_zero(regfile_lwaddr_i);
  assign rsv_ok = regfile_rsv_i && !is_zero(regfile_rsv_addr_i);

  // Reservation is applied after the clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    busy_next = busy;
    if (lwe_ok) busy_next[regfile_lwaddr_i] = 1'b0;
    if (rsv_ok) busy_next[regfile_rsv_addr_i] = 1'b1;
  end

  // State update; the short port is written last so it wins an address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (lwe_ok) regs[regfile_lwaddr_i] <= regfile_ldata_i;
      if (we_ok)  regs[regfile_waddr_i]  <= regfile_data_i;
      busy <= busy_next;
    end
  end

  assign raddr[0] = regfile_raddr_rs1_i;
  assign raddr[1] = regfile_raddr_rs2_i;
  assign raddr[2] = regfile_raddr_rs3_i;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rdata[k] = regs[raddr[k]];
      rbusy[k] = busy[raddr[k]];
      if (BYPASS != 0) begin
        if (we_ok && regfile_waddr_i == raddr[k]) begin
          rdata[k] = regfile_data_i;
        end else if (lwe_ok && regfile_lwaddr_i == raddr[k]) begin
          rdata[k] = regfile_ldata_i;
        end
        // A completing long write frees the register unless it is re-reserved now.
        if (lwe_ok && regfile_lwaddr_i == raddr[k]) begin
          rbusy[k] = rsv_ok && (regfile_rsv_addr_i == raddr[k]);
        end
      end
      if (is_zero(raddr[k])) begin
        rdata[k] = '0;
        rbusy[k] = 1'b0;
      end
    end
  end

  assign regfile_rs1_o      = rdata[0];
  assign regfile_rs2_o      = rdata[1];
  assign regfile_rs3_o      = rdata[2];
  assign regfile_rs1_busy_o = rbusy[0];
  assign regfile_rs2_busy_o = rbusy[1];
  assign regfile_rs3_busy_o = rbusy[2];
  assign regfile_busy_any_o = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two instances (hard-zero+bypass, plain) share stimulus;
// a reference model pushes expected outputs to a scoreboard queue each cycle.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  raddr1, raddr2, raddr3;
  logic        we, lwe, rsv;
  logic [4:0]  waddr, lwaddr, rsv_addr;
  logic [31:0] data, ldata;

  logic [31:0] a_rs1, a_rs2, a_rs3, b_rs1, b_rs2, b_rs3;
  logic        a_bz1, a_bz2, a_bz3, a_any, b_bz1, b_bz2, b_bz3, b_any;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  bit          hz [2] = '{1'b1, 1'b0};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [31:0] m_regs [2][32];
  bit          m_busy [2][32];

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .HARD_ZERO(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .regfile_raddr_rs1_i(raddr1), .regfile_raddr_rs2_i(raddr2), .regfile_raddr_rs3_i(raddr3),
    .regfile_rs1_o(a_rs1), .regfile_rs2_o(a_rs2), .regfile_rs3_o(a_rs3),
    .regfile_rs1_busy_o(a_bz1), .regfile_rs2_busy_o(a_bz2), .regfile_rs3_busy_o(a_bz3),
    .regfile_we_i(we), .regfile_waddr_i(waddr), .regfile_data_i(data),
    .regfile_lwe_i(lwe), .regfile_lwaddr_i(lwaddr), .regfile_ldata_i(ldata),
    .regfile_rsv_i(rsv), .regfile_rsv_addr_i(rsv_addr),
    .regfile_busy_any_o(a_any)
  );

  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .HARD_ZERO(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n),
    .regfile_raddr_rs1_i(raddr1), .regfile_raddr_rs2_i(raddr2), .regfile_raddr_rs3_i(raddr3),
    .regfile_rs1_o(b_rs1), .regfile_rs2_o(b_rs2), .regfile_rs3_o(b_rs3),
    .regfile_rs1_busy_o(b_bz1), .regfile_rs2_busy_o(b_bz2), .regfile_rs3_busy_o(b_bz3),
    .regfile_we_i(we), .regfile_waddr_i(waddr), .regfile_data_i(data),
    .regfile_lwe_i(lwe), .regfile_lwaddr_i(lwaddr), .regfile_ldata_i(ldata),
    .regfile_rsv_i(rsv), .regfile_rsv_addr_i(rsv_addr),
    .regfile_busy_any_o(b_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_zero(input int c, input logic [4:0] a);
    return hz[c] && (a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int c, input logic [4:0] a);
    if (is_zero(c, a)) return 32'h0;
    if (bp[c]) begin
      if (we && waddr == a) return data;
      if (lwe && lwaddr == a) return ldata;
    end
    return m_regs[c][a];
  endfunction

  function automatic logic [31:0] exp_busy(input int c, input logic [4:0] a);
    if (is_zero(c, a)) return 32'h0;
    if (bp[c] && lwe && lwaddr == a) return {31'h0, rsv && rsv_addr == a};
    return {31'h0, m_busy[c][a]};
  endfunction

  function automatic logic [31:0] exp_any(input int c);
    for (int i = 0; i < 32; i++) if (m_busy[c][i]) return 32'h1;
    return 32'h0;
  endfunction

  function automatic logic [31:0] obs_val(input int c, input int k);
    logic [31:0] r;
    r = 32'h0;
    case ({c[0], k[2:0]})
      4'h0: r = a_rs1;
      4'h1: r = a_rs2;
      4'h2: r = a_rs3;
      4'h3: r = {31'h0, a_bz1};
      4'h4: r = {31'h0, a_bz2};
      4'h5: r = {31'h0, a_bz3};
      4'h6: r = {31'h0, a_any};
      4'h8: r = b_rs1;
      4'h9: r = b_rs2;
      4'hA: r = b_rs3;
      4'hB: r = {31'h0, b_bz1};
      4'hC: r = {31'h0, b_bz2};
      4'hD: r = {31'h0, b_bz3};
      4'hE: r = {31'h0, b_any};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 32; i++) begin
        m_regs[c][i] = 32'h0;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic model_clock();
    for (int c = 0; c < 2; c++) begin
      if (lwe && !is_zero(c, lwaddr)) m_regs[c][lwaddr] = ldata;
      if (we && !is_zero(c, waddr)) m_regs[c][waddr] = data;
      if (lwe && !is_zero(c, lwaddr)) m_busy[c][lwaddr] = 1'b0;
      if (rsv && !is_zero(c, rsv_addr)) m_busy[c][rsv_addr] = 1'b1;
    end
  endtask

  task automatic idle();
    we = 0; lwe = 0; rsv = 0;
    waddr = 0; lwaddr = 0; rsv_addr = 0;
    data = 0; ldata = 0;
  endtask

  // Called from a negedge with inputs already driven: score, then clock the model.
  task automatic step();
    string names [7] = '{"rs1", "rs2", "rs3", "bz1", "bz2", "bz3", "any"};
    logic [4:0] ra [3];
    sb_t e;
    #1;
    ra[0] = raddr1; ra[1] = raddr2; ra[2] = raddr3;
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 7; k++) begin
        e.tag = $sformatf("c%0d_%s", c, names[k]);
        if (k < 3)      e.exp = exp_rd(c, ra[k]);
        else if (k < 6) e.exp = exp_busy(c, ra[k-3]);
        else            e.exp = exp_any(c);
        sb_q.push_back(e);
      end
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 7; k++) begin
        e = sb_q.pop_front();
        check_val(e.tag, obs_val(c, k), e.exp);
      end
    @(posedge clk);
    if (rst_n) model_clock();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0;
    idle();
    raddr1 = 1; raddr2 = 2; raddr3 = 3;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    check_val("rst_rs1", a_rs1, 32'h0);
    check_val("rst_bz1", {31'h0, a_bz1}, 32'h0);
    check_val("rst_any", {31'h0, a_any}, 32'h0);
    step();
    rst_n = 1;
    step();

    // Writes to register 0
    we = 1; waddr = 0; data = 32'hDEADBEEF;
    step();
    idle(); raddr1 = 0;
    #1;
    check_val("hz_rd0", a_rs1, 32'h0);
    check_val("nohz_rd0", b_rs1, 32'hDEADBEEF);
    step();

    // Same-cycle forwarding
    we = 1; waddr = 5; data = 32'h1234; raddr2 = 5;
    #1;
    check_val("byp_rs2", a_rs2, 32'h1234);
    check_val("nobyp_old", b_rs2, 32'h0);
    step();
    idle();
    #1;
    check_val("nobyp_new", b_rs2, 32'h1234);
    step();

    // Reserve 7, long write three cycles later
    rsv = 1; rsv_addr = 7;
    step();
    idle(); raddr1 = 7;
    #1;
    check_val("rsv_bz1", {31'h0, a_bz1}, 32'h1);
    check_val("rsv_any", {31'h0, a_any}, 32'h1);
    step();
    step();
    lwe = 1; lwaddr = 7; ldata = 32'hCAFE;
    #1;
    check_val("lw_byp_rs1", a_rs1, 32'hCAFE);
    check_val("lw_byp_bz1", {31'h0, a_bz1}, 32'h0);
    check_val("lw_nobyp_bz1", {31'h0, b_bz1}, 32'h1);
    step();
    idle();
    #1;
    check_val("lw_after_bz1", {31'h0, a_bz1}, 32'h0);
    check_val("lw_after_any", {31'h0, a_any}, 32'h0);
    check_val("lw_after_rs1", b_rs1, 32'hCAFE);
    step();

    // Port collisions on register 9
    we = 1; waddr = 9; data = 32'hA; lwe = 1; lwaddr = 9; ldata = 32'hB; raddr1 = 9;
    #1;
    check_val("coll_byp", a_rs1, 32'hA);
    step();
    idle();
    #1;
    check_val("coll_a", a_rs1, 32'hA);
    check_val("coll_b", b_rs1, 32'hA);
    step();
    rsv = 1; rsv_addr = 9;
    step();
    lwe = 1; lwaddr = 9; ldata = 32'hC;
    #1;
    check_val("setclr_byp", {31'h0, a_bz1}, 32'h1);
    step();
    idle();
    #1;
    check_val("setclr_a", {31'h0, a_bz1}, 32'h1);
    check_val("setclr_b", {31'h0, b_bz1}, 32'h1);
    step();
    lwe = 1; lwaddr = 9; ldata = 32'hD;
    step();
    idle();

    // Asynchronous reset mid-cycle
    rsv = 1; rsv_addr = 3;
    step();
    rsv_addr = 4;
    step();
    idle(); raddr1 = 3; raddr2 = 4; raddr3 = 5;
    step();
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check_val("arst_bz1", {31'h0, a_bz1}, 32'h0);
    check_val("arst_bz2", {31'h0, b_bz2}, 32'h0);
    check_val("arst_any", {31'h0, a_any}, 32'h0);
    check_val("arst_rs3", a_rs3, 32'h0);
    check_val("arst_rs3b", b_rs3, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    lwe = 1; lwaddr = 3; ldata = 32'h77;
    step();
    idle();
    #1;
    check_val("post_rst_lw", a_rs1, 32'h77);
    check_val("post_rst_bz", {31'h0, a_bz1}, 32'h0);
    step();

    // Randomised traffic over a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      we       = ($urandom_range(0, 1) == 1);
      lwe      = ($urandom_range(0, 2) == 0);
      rsv      = ($urandom_range(0, 2) == 0);
      waddr    = 5'($urandom_range(0, 7));
      lwaddr   = 5'($urandom_range(0, 7));
      rsv_addr = 5'($urandom_range(0, 7));
      raddr1   = 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      raddr3   = 5'($urandom_range(0, 7));
      data     = $urandom;
      ldata    = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
